// File: rtl/iter_shifter_pkg.sv
// ---------------------------------------------------------------------------
// iter_shifter_pkg
//   Shared constants for the multi-cycle shifter datapath.
//   - Shift operation codes used by both the one-step shifter and the
//     iterating controller.
//   - Controller state encodings (plain localparams so older code that
//     compares raw 2-bit state values keeps working).
// ---------------------------------------------------------------------------
package iter_shifter_pkg;

    // One-bit shift operation codes
    localparam logic [1:0] SH_NONE = 2'b00;  // pass-through
    localparam logic [1:0] SH_LSL  = 2'b01;  // left, LSB <- 0
    localparam logic [1:0] SH_LSR  = 2'b10;  // logical right, MSB <- 0
    localparam logic [1:0] SH_ASR  = 2'b11;  // arithmetic right, MSB kept

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;   // waiting for start
    localparam logic [1:0] ST_RUN  = 2'd1;   // one step per clock
    localparam logic [1:0] ST_FIN  = 2'd2;   // result valid, done pulse

endpackage

// File: rtl/iter_shifter_step.sv
// ---------------------------------------------------------------------------
// iter_shifter_step
//   Single-step combinational shifter: applies one one-bit shift of the
//   selected kind to its operand.
//   Ports:
//     din   [WIDTH-1:0]  operand
//     code  [1:0]        shift operation (SH_* from iter_shifter_pkg)
//     dout  [WIDTH-1:0]  operand shifted by one position (or unchanged)
// ---------------------------------------------------------------------------
module iter_shifter_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       code,
    output logic [WIDTH-1:0] dout
);

    // Pick one of the three one-bit shifts; anything else passes through
    always_comb begin
        dout = din;
        case (code)
            SH_LSL:  dout = {din[WIDTH-2:0], 1'b0};
            SH_LSR:  dout = {1'b0, din[WIDTH-1:1]};
            SH_ASR:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// ---------------------------------------------------------------------------
// iter_shifter
//   Multi-cycle variable-amount shifter with a start/done handshake. The
//   operand is captured on accept and then shifted by one bit per clock,
//   `amount` times, through a single combinational one-step shifter.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     start    request, sampled on a clk edge (only in IDLE or FIN)
//     Bin      operand, captured on accept
//     shift    operation code, captured on accept
//     amount   number of one-bit steps, captured on accept
//     busy     high while steps remain (state RUN)
//     done     one-cycle pulse when out is valid (state FIN)
//     out      result register, held until the next accept
// ---------------------------------------------------------------------------
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Bin,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    logic [1:0]       state;
    logic [1:0]       code;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] step_out;

    iter_shifter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (out),
        .code (code),
        .dout (step_out)
    );

    // Controller: FIN accepts a new start just like IDLE so operations can
    // run back to back. A zero-step request (amount 0 or no-op code) skips
    // RUN entirely and goes straight to FIN with the operand unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            out   <= '0;
            code  <= SH_NONE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        out  <= Bin;
                        code <= shift;
                        if (amount == '0 || shift == SH_NONE) begin
                            count <= '0;
                            state <= ST_FIN;
                        end else begin
                            count <= amount;
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    out   <= step_out;
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= ST_FIN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_FIN);

endmodule
